projectile_engine: RTL and testbench



---
 rtl/rager_pkg.sv | 25 ++
 rtl/projectile_engine_bullet_hit.sv | 30 +++
 rtl/projectile_engine.sv | 184 ++++++++++++++++++
 tb/tb_projectile_engine.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rager_pkg.sv
// Shared types for the rager game video blocks.
//   SCREEN_W / SCREEN_H : visible raster size in pixels
//   coord_t             : 10-bit pixel coordinate
//   bullet_t            : one projectile pool slot {active, x, y}
//   proj_state_t        : projectile_engine frame-update FSM encoding
package rager_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   typedef logic [9:0] coord_t;

   typedef struct packed {
      logic   active;
      coord_t x;
      coord_t y;
   } bullet_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MOVE  = 2'd1,
      SPAWN = 2'd2
   } proj_state_t;

endpackage

// File: rtl/projectile_engine_bullet_hit.sv
// bullet_hit: combinational box test of one pool slot against the current pixel.
//   slot   in  : pool slot (active, centre x/y)
//   draw_x in  : current pixel column
//   draw_y in  : current pixel row
//   hit    out : slot is live and the pixel lies within +/-SIZE of its centre
module bullet_hit
   import rager_pkg::*;
#(
   parameter int SIZE = 2
) (
   input  bullet_t slot,
   input  coord_t  draw_x,
   input  coord_t  draw_y,
   output logic    hit
);

   localparam logic signed [10:0] LIM = 11'(SIZE);

   logic signed [10:0] dx;
   logic signed [10:0] dy;

   // Zero-extend to 11 bits so the difference of two 10-bit coordinates is exact.
   assign dx = $signed({1'b0, draw_x}) - $signed({1'b0, slot.x});
   assign dy = $signed({1'b0, draw_y}) - $signed({1'b0, slot.y});

   assign hit = slot.active
              && (dx >= -LIM) && (dx <= LIM)
              && (dy >= -LIM) && (dy <= LIM);

endmodule

// File: rtl/projectile_engine.sv
// projectile_engine: player bullet pool for the rager VGA game.
// Spawns a bullet at the player on the shoot key, moves live bullets up once
// per frame (on the vsync falling edge) and answers a registered per-pixel
// "bullet here?" query for color_mapper.
//
// Ports:
//   Clk          in  : system clock
//   Reset        in  : asynchronous, active-high clear
//   vsync        in  : VGA vertical sync, active-low, Clk domain
//   Start        in  : game running; low clears and holds the pool
//   keycodeshoot in  : keycode from the SoC PIO
//   Player_X/Y   in  : spawn position
//   DrawX/DrawY  in  : current pixel
//   bullet_on    out : pixel from the previous cycle lies inside a live bullet
//   fire_evt     out : one-cycle pulse, high in the cycle a new bullet appears
//   active_count out : number of live slots (one cycle behind slot state)
//
// Build option: define RAGER_AUTOFIRE_EN to refire while the key is held
// (rate limited by COOLDOWN_FRAMES); otherwise each press fires at most once.
//
// state | meaning
// IDLE  | wait for the frame tick (vsync falling edge) while Start is high
// MOVE  | advance/retire every live slot, step cooldown, sample the shoot key
// SPAWN | place a bullet in the lowest free slot if triggered and allowed
module projectile_engine
   import rager_pkg::*;
#(
   parameter int         NUM_BULLETS     = 4,
   parameter int         BULLET_SPEED    = 4,
   parameter int         BULLET_SIZE     = 2,
   parameter int         COOLDOWN_FRAMES = 8,
   parameter logic [7:0] SHOOT_KEY       = 8'h2C
) (
   input  logic                             Clk,
   input  logic                             Reset,
   input  logic                             vsync,
   input  logic                             Start,
   input  logic [7:0]                       keycodeshoot,
   input  logic [9:0]                       Player_X,
   input  logic [9:0]                       Player_Y,
   input  logic [9:0]                       DrawX,
   input  logic [9:0]                       DrawY,
   output logic                             bullet_on,
   output logic                             fire_evt,
   output logic [$clog2(NUM_BULLETS+1)-1:0] active_count
);

   localparam int     CNT_W    = $clog2(NUM_BULLETS + 1);
   // +2 keeps the counter at least one bit wide when COOLDOWN_FRAMES is 0.
   localparam int     CD_W     = $clog2(COOLDOWN_FRAMES + 2);
   localparam coord_t RETIRE_Y = coord_t'(BULLET_SPEED + BULLET_SIZE);
   localparam coord_t STEP     = coord_t'(BULLET_SPEED);

   proj_state_t      state_q, state_d;
   bullet_t          slot_q [NUM_BULLETS];
   bullet_t          slot_d [NUM_BULLETS];
   logic [CD_W-1:0]  cooldown_q, cooldown_d;
   logic             vsync_q;
   logic             pressed_q, pressed_d;
   logic             pressed_prev_q, pressed_prev_d;
   logic             fire_q, fire_d;
   logic             bullet_on_q, bullet_on_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic                   tick;
   logic                   trigger;
   logic                   free_any;
   logic                   placed;
   logic                   spawn_ok;
   logic [NUM_BULLETS-1:0] hit_vec;

   assign tick = vsync_q & ~vsync;

`ifdef RAGER_AUTOFIRE_EN
   assign trigger = pressed_q;
`else
   // Edge detect across frames: the key must be seen released at a tick first.
   assign trigger = pressed_q & ~pressed_prev_q;
`endif

   for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_hit
      bullet_hit #(
         .SIZE (BULLET_SIZE)
      ) u_hit (
         .slot   (slot_q[g]),
         .draw_x (DrawX),
         .draw_y (DrawY),
         .hit    (hit_vec[g])
      );
   end

   always_comb begin
      state_d        = state_q;
      cooldown_d     = cooldown_q;
      pressed_d      = pressed_q;
      pressed_prev_d = pressed_prev_q;
      spawn_ok       = 1'b0;
      placed         = 1'b0;
      free_any       = 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         slot_d[i] = slot_q[i];
         if (!slot_q[i].active) free_any = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (tick) state_d = MOVE;
         end
         MOVE: begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
               if (slot_q[i].active) begin
                  if (slot_q[i].y < RETIRE_Y) slot_d[i].active = 1'b0;
                  else                        slot_d[i].y = slot_q[i].y - STEP;
               end
            end
            if (cooldown_q != '0) cooldown_d = cooldown_q - 1'b1;
            pressed_d      = (keycodeshoot == SHOOT_KEY);
            pressed_prev_d = pressed_q;
            state_d        = SPAWN;
         end
         SPAWN: begin
            if (trigger && (cooldown_q == '0) && free_any) begin
               spawn_ok   = 1'b1;
               cooldown_d = CD_W'(COOLDOWN_FRAMES);
               for (int i = 0; i < NUM_BULLETS; i++) begin
                  if (!placed && !slot_q[i].active) begin
                     placed    = 1'b1;
                     slot_d[i] = '{active: 1'b1, x: Player_X, y: Player_Y};
                  end
               end
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Start low wins over any frame update in flight.
      if (!Start) begin
         state_d        = IDLE;
         cooldown_d     = '0;
         pressed_d      = 1'b0;
         pressed_prev_d = 1'b0;
         spawn_ok       = 1'b0;
         for (int i = 0; i < NUM_BULLETS; i++) slot_d[i] = '0;
      end
   end

   always_comb begin
      count_d = '0;
      for (int i = 0; i < NUM_BULLETS; i++) count_d = count_d + CNT_W'(slot_q[i].active);
   end

   assign fire_d      = spawn_ok;
   assign bullet_on_d = |hit_vec;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q        <= IDLE;
         cooldown_q     <= '0;
         vsync_q        <= 1'b0;
         pressed_q      <= 1'b0;
         pressed_prev_q <= 1'b0;
         fire_q         <= 1'b0;
         bullet_on_q    <= 1'b0;
         count_q        <= '0;
         for (int i = 0; i < NUM_BULLETS; i++) slot_q[i] <= '0;
      end else begin
         state_q        <= state_d;
         cooldown_q     <= cooldown_d;
         vsync_q        <= vsync;
         pressed_q      <= pressed_d;
         pressed_prev_q <= pressed_prev_d;
         fire_q         <= fire_d;
         bullet_on_q    <= bullet_on_d;
         count_q        <= count_d;
         for (int i = 0; i < NUM_BULLETS; i++) slot_q[i] <= slot_d[i];
      end
   end

   assign bullet_on    = bullet_on_q;
   assign fire_evt     = fire_q;
   assign active_count = count_q;

endmodule

// File: tb/tb_projectile_engine.sv
module tb_projectile_engine;

`ifdef RAGER_AUTOFIRE_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       vsync;
   logic       start;
   logic [7:0] key;
   logic [9:0] px, py, draw_x, draw_y;

   logic       on_a, fire_a;
   logic [2:0] cnt_a;
   logic       on_b, fire_b;
   logic [2:0] cnt_b;

   int tests = 0;
   int fails = 0;
   int fires_a = 0;
   int fires_b = 0;

   always #5 clk = ~clk;

   // Default configuration.
   projectile_engine dut (
      .Clk (clk), .Reset (rst), .vsync (vsync), .Start (start),
      .keycodeshoot (key), .Player_X (px), .Player_Y (py),
      .DrawX (draw_x), .DrawY (draw_y),
      .bullet_on (on_a), .fire_evt (fire_a), .active_count (cnt_a)
   );

   // No cooldown, for pool-full behaviour.
   projectile_engine #(.COOLDOWN_FRAMES (0)) dut_cd0 (
      .Clk (clk), .Reset (rst), .vsync (vsync), .Start (start),
      .keycodeshoot (key), .Player_X (px), .Player_Y (py),
      .DrawX (draw_x), .DrawY (draw_y),
      .bullet_on (on_b), .fire_evt (fire_b), .active_count (cnt_b)
   );

   always @(negedge clk) begin
      if (fire_a) fires_a++;
      if (fire_b) fires_b++;
   end

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       exp_on;
   } pix_vec_t;

   pix_vec_t vecs [10];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One video frame: vsync falls, FSM runs MOVE and SPAWN, vsync rises again.
   task automatic frame();
      @(negedge clk) vsync = 1'b0;
      repeat (6) @(negedge clk);
      vsync = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic probe(input string name, input bit which, input int x, input int y,
                        input int exp);
      @(negedge clk);
      draw_x = 10'(x);
      draw_y = 10'(y);
      @(posedge clk);
      #1;
      check(name, which ? int'(on_b) : int'(on_a), exp);
   endtask

   task automatic clear_pool();
      @(negedge clk) start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
   endtask

   // A one-frame press followed by a release frame (release is what re-arms the
   // non-autofire build).
   task automatic shot();
      key = 8'h2C;
      frame();
      key = 8'h00;
      frame();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int base_a, base_b;

      // Bullet sits at (320,396) when the table is applied.
      vecs[0] = '{x: 10'd321, y: 10'd397, exp_on: 1'b1};
      vecs[1] = '{x: 10'd323, y: 10'd397, exp_on: 1'b0};
      vecs[2] = '{x: 10'd320, y: 10'd396, exp_on: 1'b1};
      vecs[3] = '{x: 10'd318, y: 10'd394, exp_on: 1'b1};
      vecs[4] = '{x: 10'd317, y: 10'd394, exp_on: 1'b0};
      vecs[5] = '{x: 10'd322, y: 10'd398, exp_on: 1'b1};
      vecs[6] = '{x: 10'd322, y: 10'd399, exp_on: 1'b0};
      vecs[7] = '{x: 10'd320, y: 10'd393, exp_on: 1'b0};
      vecs[8] = '{x: 10'd320, y: 10'd400, exp_on: 1'b0};
      vecs[9] = '{x: 10'd100, y: 10'd100, exp_on: 1'b0};

      rst = 1'b1; vsync = 1'b1; start = 1'b0; key = 8'h00;
      px = 10'd320; py = 10'd400; draw_x = 10'd0; draw_y = 10'd0;
      repeat (3) @(negedge clk);
      check("reset bullet_on", int'(on_a), 0);
      check("reset fire_evt", int'(fire_a), 0);
      check("reset active_count", int'(cnt_a), 0);
      check("reset active_count cd0", int'(cnt_b), 0);
      rst = 1'b0;
      @(negedge clk) start = 1'b1;

      // Idle frames with no key.
      base_a = fires_a;
      repeat (5) frame();
      check("idle fires", fires_a - base_a, 0);
      check("idle active_count", int'(cnt_a), 0);
      probe("idle bullet_on", 1'b0, 320, 400, 0);

      // Single shot at (320,400).
      base_a = fires_a;
      key = 8'h2C;
      frame();
      key = 8'h00;
      check("shot fires", fires_a - base_a, 1);
      check("shot active_count", int'(cnt_a), 1);
      probe("spawn centre", 1'b0, 320, 400, 1);
      probe("spawn above", 1'b0, 320, 397, 0);
      probe("spawn below", 1'b0, 320, 403, 0);
      frame();
      check("release no fire", fires_a - base_a, 1);
      for (int i = 0; i < 10; i++)
         probe($sformatf("pix vec %0d", i), 1'b0, int'(vecs[i].x), int'(vecs[i].y),
               int'(vecs[i].exp_on));

      // Start low clears the pool.
      clear_pool();
      check("start clear active_count", int'(cnt_a), 0);
      probe("start clear bullet_on", 1'b0, 320, 396, 0);

      // Key held for 20 frames.
      base_a = fires_a;
      base_b = fires_b;
      key = 8'h2C;
      repeat (20) frame();
      key = 8'h00;
      check("hold fires", fires_a - base_a, AUTO ? 3 : 1);
      check("hold active_count", int'(cnt_a), AUTO ? 3 : 1);
      check("hold fires cd0", fires_b - base_b, AUTO ? 4 : 1);

      // Pool full with no cooldown.
      clear_pool();
      base_b = fires_b;
      repeat (4) shot();
      check("pool fill fires", fires_b - base_b, 4);
      check("pool fill active_count", int'(cnt_b), 4);
      shot();
      check("pool full no fire", fires_b - base_b, 4);
      check("pool full active_count", int'(cnt_b), 4);

      // Spawn near the top: retires on the third move.
      clear_pool();
      py = 10'd10;
      base_a = fires_a;
      key = 8'h2C;
      frame();
      key = 8'h00;
      check("top spawn fires", fires_a - base_a, 1);
      probe("top y10", 1'b0, 320, 10, 1);
      frame();
      probe("top y6", 1'b0, 320, 6, 1);
      probe("top not y9", 1'b0, 320, 9, 0);
      frame();
      probe("top y2", 1'b0, 320, 2, 1);
      probe("top not y5", 1'b0, 320, 5, 0);
      check("top before retire count", int'(cnt_a), 1);
      frame();
      check("top retired count", int'(cnt_a), 0);
      probe("top retired bullet_on", 1'b0, 320, 2, 0);
      py = 10'd400;

      // Three bullets, then Start dropped.
      clear_pool();
      repeat (3) shot();
      check("three live cd0", int'(cnt_b), 3);
      probe("three live bullet_on", 1'b1, 320, 396, 1);
      @(negedge clk) start = 1'b0;
      repeat (2) @(negedge clk);
      check("start drop count", int'(cnt_b), 0);
      probe("start drop bullet_on", 1'b1, 320, 396, 0);
      start = 1'b1;

      // Three bullets, then Reset pulsed in the middle of a frame update.
      repeat (3) shot();
      check("three live again", int'(cnt_b), 3);
      draw_x = 10'd320; draw_y = 10'd396;
      @(negedge clk) vsync = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("async reset count", int'(cnt_b), 0);
      check("async reset bullet_on", int'(on_b), 0);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);
      vsync = 1'b1;
      repeat (2) @(negedge clk);
      probe("after reset bullet_on", 1'b1, 320, 396, 0);
      base_b = fires_b;
      shot();
      check("resume fires", fires_b - base_b, 1);
      check("resume count", int'(cnt_b), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
